// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous video-RAM port between the display
// pixel fetch (absolute priority, granted in the cycle it is requested) and a
// host read/write port. Host operations wait in a one-entry buffer until a
// cycle with no display request. A saturating wait counter drives a sticky
// starvation flag.
module vram_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 3,
  parameter int MAX_WAIT = 1023,
  parameter int WW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_rvalid,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          host_starve,
  input  logic          starve_clr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Which requester owns the RAM read data returning in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  // One-entry host buffer.
  logic          pend;
  logic          pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_wdata;

  owner_t        owner;
  logic [WW-1:0] wait_cnt;

  logic accept;
  logic drain;
  logic blocked;

  // Saturating increment of the host wait counter.
  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    return (v >= WAIT_MAX) ? v : v + 1'b1;
  endfunction

  // The buffer can take a new entry whenever it is empty or draining now.
  assign host_ready = !pend || !disp_req;
  assign accept     = host_valid && host_ready;
  assign drain      = pend && !disp_req;
  assign blocked    = pend && disp_req;

  // Read data is a straight pass-through; the owner register qualifies it.
  assign disp_rdata  = mem_rdata;
  assign host_rdata  = mem_rdata;
  assign disp_rvalid = (owner == OWN_DISP);
  assign host_rvalid = (owner == OWN_HOST);

  // RAM port issue: display first, then the buffered host operation.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (pend) begin
      mem_en    = 1'b1;
      mem_we    = pend_we;
      mem_addr  = pend_addr;
      mem_wdata = pend_wdata;
    end
  end

  // Buffer occupancy: a same-cycle accept replaces the draining entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (accept) begin
      pend <= 1'b1;
    end else if (drain) begin
      pend <= 1'b0;
    end
  end

  // Buffer payload; only meaningful while pend is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_we    <= host_we;
      pend_addr  <= host_addr;
      pend_wdata <= host_wdata;
    end
  end

  // Read owner for the data returning next cycle; host writes return nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= OWN_NONE;
    end else if (disp_req) begin
      owner <= OWN_DISP;
    end else if (drain && !pend_we) begin
      owner <= OWN_HOST;
    end else begin
      owner <= OWN_NONE;
    end
  end

  // Count cycles the pending host operation is held off by the display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (drain) begin
      wait_cnt <= '0;
    end else if (blocked) begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  // Sticky starvation flag; a new set beats a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_starve <= 1'b0;
    end else if (blocked && (wait_cnt == WAIT_MAX)) begin
      host_starve <= 1'b1;
    end else if (starve_clr) begin
      host_starve <= 1'b0;
    end
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbiter for the single-port video RAM feeding the VGA output path. It shares one synchronous RAM port between the display pixel fetch and a host read/write port. The display fetch has absolute priority and is granted in the cycle it is requested. Host operations wait in a one-entry buffer until a cycle with no display request, and a sticky flag reports host starvation. It sits between the VGA controller's pixel-address logic and the frame-buffer RAM.

## Interface
- AW, 15: RAM address width (160x120 frame = 19200 words).
- DW, 3: RAM data width (R, G, B bits).
- MAX_WAIT, 1023: blocked-cycle count at which host_starve sets.
- WW, 10: wait-counter width; must satisfy 2^WW-1 >= MAX_WAIT.
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- disp_req  in  1  display fetch request for this cycle.
- disp_addr  in  AW  display fetch address.
- disp_rdata  out  DW  display read data (mem_rdata pass-through).
- disp_rvalid  out  1  disp_rdata valid this cycle.
- host_valid  in  1  host operation offered.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_ready  out  1  host operation accepted when valid and ready are both high.
- host_rdata  out  DW  host read data (mem_rdata pass-through).
- host_rvalid  out  1  host_rdata valid this cycle.
- host_starve  out  1  sticky starvation flag.
- starve_clr  in  1  clears host_starve.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid one cycle after a read is issued.

## Operation
- Buffer state: pend, pend_we, pend_addr, pend_wdata.
- Accept: when host_valid and host_ready are both high, load the buffer and set pend.
- Issue rules (combinational, same cycle):
  - If disp_req is high: mem_en=1, mem_we=0, mem_addr=disp_addr. The display request is granted.
  - Else if pend is high: mem_en=1, mem_we=pend_we, mem_addr=pend_addr, mem_wdata=pend_wdata. The buffer drains at the clock edge.
  - Else: mem_en=0, mem_we=0.
- host_ready = !pend || !disp_req. Accept and drain in the same cycle are allowed, so a new entry replaces the draining one. With the display idle, the host sustains one operation per cycle.
- Read owner register: set to DISP when a display read is issued, HOST when a host read is issued, NONE otherwise.
  - disp_rvalid = (owner == DISP).
  - host_rvalid = (owner == HOST).
  - Host writes produce no rvalid.
- Wait counter (WW bits):
  - Increments each cycle that pend=1 and disp_req=1, saturating at MAX_WAIT.
  - Clears to 0 in any cycle the buffer drains.
- host_starve:
  - Sets on the cycle the counter equals MAX_WAIT while still blocked.
  - Holds until starve_clr. If set and clear coincide, set wins.
- Outputs hold their reset values when idle: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: pend=0, owner=NONE, counter=0, host_starve=0.
  - Therefore host_ready=1, disp_rvalid=0, host_rvalid=0, mem_en=0, mem_we=0.
  - mem_addr and mem_wdata are 0 unless disp_req is driven during reset.
- Display latency: request in cycle N, disp_rvalid and data in cycle N+1, every cycle, regardless of host activity.
- Host latency, display idle: accept in N, issue in N+1, read data in N+2.
- Host latency, display busy: issue occurs in the first cycle with disp_req=0.
- Reset mid-operation: the pending host operation is discarded with no RAM write, and in-flight rvalid is dropped.
- No combinational path from mem_rdata to any control output.

## Test plan
- Reset, then host write of addr 5, data 3, with display idle.
  - Required: host_ready=1; mem_we=1, mem_addr=5 one cycle after accept.
  - Follow with a host read of addr 5: host_rvalid=1 and host_rdata=3 two cycles after accept.
- Display streaming addresses 0..15 for 16 cycles while a host write to addr 100 is offered at cycle 2.
  - Required: every display read issued on its cycle with disp_rvalid the following cycle.
  - Host write issues on the first cycle with disp_req=0.
  - host_ready=0 from the accept cycle +1 until that drain cycle.
- Display idle, host offers 4 back-to-back writes.
  - Required: host_ready stays 1; 4 consecutive mem_we pulses.
- MAX_WAIT=8, disp_req held high, one host read pending.
  - Required: host_starve rises when the counter reaches 8 and stays high after disp_req drops.
  - starve_clr asserted in the same cycle as a new set leaves host_starve=1.
- Assert reset while a host write is pending and a display read is in flight.
  - Required: all outputs at reset values immediately.
  - No mem_we pulse after reset release; host_ready=1.
